riscv_regfile_mp: RTL and testbench
===================================

# riscv_regfile_mp

Parametrised multi-read-port RISC-V integer register file with one clocked write port, optional write-to-read bypass, a per-register pending scoreboard for in-flight writebacks, and a post-reset zeroing sweep. It sits between decode/issue and writeback in the core pipeline. Decode reads operands and pending flags from it, and writeback retires results into it. x0 always reads 0 and is never pending.

## Interface
- NUM_REG, 32, number of architectural registers; power of two, ≥2
- WIDTH, 32, data width in bits
- NUM_RD, 2, number of combinational read ports, 1..4
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = no forwarding
- AW (derived), $clog2(NUM_REG), address width
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset; asserting it clears all state immediately
- init_done  out  1  high once the zeroing sweep has completed
- write_enable  in  1  writeback strobe
- write_addr  in  AW  writeback destination
- write_data  in  WIDTH  writeback value
- issue_valid  in  1  an instruction with destination issue_addr has been issued
- issue_addr  in  AW  destination register to mark pending
- flush  in  1  clear every pending bit; pipeline squash
- rd_addr  in  NUM_RD×AW  read addresses, packed array [NUM_RD]
- rd_data  out  NUM_RD×WIDTH  read data per port
- rd_pending  out  NUM_RD  pending flag of the addressed register per port

## Operation
- FSM states: INIT, RUN. Reset enters INIT with sweep counter = 1.
- INIT: each cycle writes 0 to reg[counter] and increments the counter. After writing reg[NUM_REG-1], the FSM moves to RUN. The sweep writes NUM_REG-1 registers.
- In INIT, write_enable, issue_valid and flush are ignored, all rd_data read 0, and all rd_pending read 0.
- RUN: write_enable with write_addr≠0 stores write_data at posedge. Writes to address 0 are discarded.
- Scoreboard: one pending bit per register 1..NUM_REG-1. Bit 0 is hardwired 0.
  - issue_valid with issue_addr≠0 sets the bit.
  - write_enable with write_addr≠0 clears the bit.
  - Issue and write to the same address in the same cycle leave the bit set (a new producer has been issued).
  - flush clears all bits and takes priority over a same-cycle issue. A same-cycle write still updates data.
- Read port p:
  - rd_addr[p]==0 gives rd_data=0 and rd_pending=0.
  - With BYPASS=1, if write_enable and write_addr==rd_addr[p]≠0, then rd_data[p]=write_data and rd_pending[p]=0.
  - Otherwise rd_data[p]=reg[rd_addr[p]] and rd_pending[p]=pending[rd_addr[p]].
- With BYPASS=0, reads see only the stored state; a write becomes visible in the next cycle.

## Timing
- Reset values: init_done=0, FSM=INIT, counter=1, all pending=0. Register contents are undefined until the sweep writes them, but they are never visible, because reads are forced to 0 in INIT.
- init_done rises on the posedge after reg[NUM_REG-1] is written, i.e. NUM_REG-1 clocks after rst deasserts (31 for the defaults).
- Reads are combinational, with zero latency. Writes, pending set and pending clear take effect at the next posedge.
- Reset asserted mid-sweep or in RUN: the block returns to INIT immediately, and the sweep restarts from 1 after deassertion.
- All read ports are independent. Any number of ports may address the same register.

## Structure
- riscv_regfile_pkg: state enum typedef (INIT, RUN) and a localparam helper for AW.
- The sub-module riscv_regfile_scoreboard holds the pending-bit vector, the set/clear/flush priority logic and the per-port pending lookup.
- Data storage, the sweep FSM and bypass muxing live in the top module.

## Test plan
- Reset, then hold all inputs idle → init_done=0 for 31 cycles, then 1; every register then reads 0, and rd_addr=5 returns 0 during INIT.
- Write 0xDEADBEEF to x7 with port 0 and port 1 both reading x7 in the same cycle → with BYPASS=1 both return 0xDEADBEEF that cycle; with BYPASS=0 both return 0 that cycle and 0xDEADBEEF in the next.
- Write 0x1234 to x0, then read x0 → returns 0, and rd_pending for x0 stays 0.
- Issue x3, wait 2 cycles → rd_pending=1. Then write x3 with 0x55 → cleared on the next cycle, and it reads 0x55.
- Issue x9 and write x9 in the same cycle → pending for x9 remains 1. Then flush together with issue x10 → pending for both x9 and x10 is 0.
- Assert rst after 10 cycles of RUN with x4=0xA5 → init_done drops immediately; after the 31-cycle re-sweep, x4 reads 0.

Source files
------------

// File: rtl/riscv_regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// Sweep FSM states and address-width helper.
package riscv_regfile_pkg;

   typedef enum logic {
      INIT,
      RUN
   } rf_state_e;

   localparam int RF_NUM_REG = 32;

   function automatic int rf_aw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/riscv_regfile_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, x0 hardwired clear.
// Flush beats issue, issue beats same-cycle writeback clear.
module riscv_regfile_scoreboard
   import riscv_regfile_pkg::*;
#(
   parameter int NUM_REG = RF_NUM_REG,
   parameter int NUM_RD  = 2,
   parameter int AW      = rf_aw(NUM_REG)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       run,
   input  logic                       issue_valid,
   input  logic [AW-1:0]              issue_addr,
   input  logic                       write_enable,
   input  logic [AW-1:0]              write_addr,
   input  logic                       flush,
   input  logic [NUM_RD-1:0][AW-1:0]  rd_addr,
   output logic [NUM_RD-1:0]          rd_pend
);

   logic [NUM_REG-1:0] pend_q;
   logic [NUM_REG-1:0] pend_d;

   always_comb begin
      pend_d = pend_q;
      if (run) begin
         for (int i = 1; i < NUM_REG; i++) begin
            if (flush) begin
               pend_d[i] = 1'b0;
            end else if (issue_valid && issue_addr == AW'(i)) begin
               pend_d[i] = 1'b1;
            end else if (write_enable && write_addr == AW'(i)) begin
               pend_d[i] = 1'b0;
            end
         end
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   always_comb begin
      rd_pend = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         rd_pend[p] = pend_q[rd_addr[p]];
      end
   end

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-read-port RISC-V integer register file with write bypass,
// pending scoreboard and post-reset zeroing sweep.
module riscv_regfile_mp
   import riscv_regfile_pkg::*;
#(
   parameter int NUM_REG = RF_NUM_REG,
   parameter int WIDTH   = 32,
   parameter int NUM_RD  = 2,
   parameter int BYPASS  = 1,
   parameter int AW      = rf_aw(NUM_REG)
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         init_done,
   input  logic                         write_enable,
   input  logic [AW-1:0]                write_addr,
   input  logic [WIDTH-1:0]             write_data,
   input  logic                         issue_valid,
   input  logic [AW-1:0]                issue_addr,
   input  logic                         flush,
   input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
   output logic [NUM_RD-1:0][WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_pending
);

   rf_state_e          state_q;
   rf_state_e          state_d;
   logic [AW-1:0]      cnt_q;
   logic [AW-1:0]      cnt_d;
   logic [WIDTH-1:0]   mem [NUM_REG];
   logic [NUM_RD-1:0]  sb_pend;
   logic               run;
   logic               wr_hit;

   assign run       = (state_q == RUN);
   assign init_done = run;
   assign wr_hit    = run && write_enable && (write_addr != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INIT;
         cnt_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         INIT: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(NUM_REG - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   // Storage has no reset; the sweep defines it before reads are unmasked.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[cnt_q] <= '0;
      end else if (wr_hit) begin
         mem[write_addr] <= write_data;
      end
   end

   riscv_regfile_scoreboard #(
      .NUM_REG (NUM_REG),
      .NUM_RD  (NUM_RD),
      .AW      (AW)
   ) u_sb (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .issue_valid  (issue_valid),
      .issue_addr   (issue_addr),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .flush        (flush),
      .rd_addr      (rd_addr),
      .rd_pend      (sb_pend)
   );

   always_comb begin
      rd_data    = '0;
      rd_pending = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (run && rd_addr[p] != '0) begin
            if (BYPASS != 0 && wr_hit && write_addr == rd_addr[p]) begin
               rd_data[p]    = write_data;
               rd_pending[p] = 1'b0;
            end else begin
               rd_data[p]    = mem[rd_addr[p]];
               rd_pending[p] = sb_pend[p];
            end
         end
      end
   end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench for riscv_regfile_mp: bypass and no-bypass instances
// share one stimulus stream.
module tb_riscv_regfile_mp;

   logic             clk;
   logic             rst;
   logic             init_done;
   logic             init_done_nb;
   logic             write_enable;
   logic [4:0]       write_addr;
   logic [31:0]      write_data;
   logic             issue_valid;
   logic [4:0]       issue_addr;
   logic             flush;
   logic [1:0][4:0]  rd_addr;
   logic [1:0][31:0] rd_data;
   logic [1:0][31:0] rd_data_nb;
   logic [1:0]       rd_pending;
   logic [1:0]       rd_pending_nb;

   int n_cmp = 0;
   int n_err = 0;

   riscv_regfile_mp #(
      .NUM_REG (32),
      .WIDTH   (32),
      .NUM_RD  (2),
      .BYPASS  (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .init_done    (init_done),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .issue_valid  (issue_valid),
      .issue_addr   (issue_addr),
      .flush        (flush),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .rd_pending   (rd_pending)
   );

   riscv_regfile_mp #(
      .NUM_REG (32),
      .WIDTH   (32),
      .NUM_RD  (2),
      .BYPASS  (0)
   ) dut_nb (
      .clk          (clk),
      .rst          (rst),
      .init_done    (init_done_nb),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .issue_valid  (issue_valid),
      .issue_addr   (issue_addr),
      .flush        (flush),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data_nb),
      .rd_pending   (rd_pending_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      write_enable = 1'b0;
      write_addr   = '0;
      write_data   = '0;
      issue_valid  = 1'b0;
      issue_addr   = '0;
      flush        = 1'b0;
   endtask

   initial begin
      rst     = 1'b0;
      rd_addr = '0;
      idle();
      #1;
      chk("reset_init_done", {31'b0, init_done}, 32'd0);
      tick();
      tick();
      rst        = 1'b1;
      rd_addr[0] = 5'd5;
      for (int k = 1; k <= 31; k++) begin
         tick();
         if (k < 31) begin
            chk("sweep_init_done", {31'b0, init_done}, 32'd0);
            chk("sweep_rd5", rd_data[0], 32'd0);
         end else begin
            chk("sweep_done", {31'b0, init_done}, 32'd1);
            chk("sweep_done_nb", {31'b0, init_done_nb}, 32'd1);
         end
      end

      for (int i = 0; i < 32; i++) begin
         rd_addr[0] = 5'(i);
         rd_addr[1] = 5'(31 - i);
         #1;
         chk("zero_p0", rd_data[0], 32'd0);
         chk("zero_p1", rd_data_nb[1], 32'd0);
         chk("zero_pend", {30'b0, rd_pending}, 32'd0);
      end

      rd_addr      = {5'd7, 5'd7};
      write_enable = 1'b1;
      write_addr   = 5'd7;
      write_data   = 32'hDEADBEEF;
      #1;
      chk("byp_p0", rd_data[0], 32'hDEADBEEF);
      chk("byp_p1", rd_data[1], 32'hDEADBEEF);
      chk("nobyp_p0", rd_data_nb[0], 32'd0);
      chk("nobyp_p1", rd_data_nb[1], 32'd0);
      tick();
      idle();
      #1;
      chk("nobyp_next_p0", rd_data_nb[0], 32'hDEADBEEF);
      chk("nobyp_next_p1", rd_data_nb[1], 32'hDEADBEEF);
      chk("byp_next_p0", rd_data[0], 32'hDEADBEEF);

      rd_addr      = {5'd0, 5'd0};
      write_enable = 1'b1;
      write_addr   = 5'd0;
      write_data   = 32'h1234;
      #1;
      chk("x0_byp", rd_data[0], 32'd0);
      tick();
      idle();
      #1;
      chk("x0_data", rd_data[0], 32'd0);
      chk("x0_data_nb", rd_data_nb[1], 32'd0);
      chk("x0_pend", {30'b0, rd_pending}, 32'd0);

      issue_valid = 1'b1;
      issue_addr  = 5'd3;
      tick();
      idle();
      tick();
      rd_addr = {5'd0, 5'd3};
      #1;
      chk("x3_pend", {31'b0, rd_pending[0]}, 32'd1);
      chk("x3_pend_nb", {31'b0, rd_pending_nb[0]}, 32'd1);
      write_enable = 1'b1;
      write_addr   = 5'd3;
      write_data   = 32'h55;
      #1;
      chk("x3_byp_pend", {31'b0, rd_pending[0]}, 32'd0);
      chk("x3_byp_data", rd_data[0], 32'h55);
      chk("x3_nobyp_pend", {31'b0, rd_pending_nb[0]}, 32'd1);
      tick();
      idle();
      #1;
      chk("x3_clr", {31'b0, rd_pending[0]}, 32'd0);
      chk("x3_clr_nb", {31'b0, rd_pending_nb[0]}, 32'd0);
      chk("x3_data", rd_data_nb[0], 32'h55);

      issue_valid  = 1'b1;
      issue_addr   = 5'd9;
      write_enable = 1'b1;
      write_addr   = 5'd9;
      write_data   = 32'h99;
      tick();
      idle();
      rd_addr = {5'd9, 5'd10};
      #1;
      chk("x9_pend", {31'b0, rd_pending[1]}, 32'd1);
      chk("x9_data", rd_data[1], 32'h99);
      chk("x10_idle", {31'b0, rd_pending[0]}, 32'd0);
      flush       = 1'b1;
      issue_valid = 1'b1;
      issue_addr  = 5'd10;
      tick();
      idle();
      #1;
      chk("flush_x9", {31'b0, rd_pending[1]}, 32'd0);
      chk("flush_x10", {31'b0, rd_pending[0]}, 32'd0);
      chk("flush_nb", {30'b0, rd_pending_nb}, 32'd0);

      write_enable = 1'b1;
      write_addr   = 5'd4;
      write_data   = 32'hA5;
      tick();
      idle();
      rd_addr = {5'd6, 5'd4};
      #1;
      chk("x4_a5", rd_data_nb[0], 32'hA5);
      for (int k = 0; k < 10; k++) begin
         tick();
      end
      rst = 1'b0;
      #1;
      chk("rst_drop", {31'b0, init_done}, 32'd0);
      chk("rst_rd4", rd_data[0], 32'd0);
      tick();
      rst          = 1'b1;
      write_enable = 1'b1;
      write_addr   = 5'd4;
      write_data   = 32'hFF;
      issue_valid  = 1'b1;
      issue_addr   = 5'd6;
      for (int k = 1; k <= 31; k++) begin
         tick();
         if (k == 30) begin
            chk("resweep_30", {31'b0, init_done}, 32'd0);
         end
         if (k < 31) begin
            chk("resweep_rd", rd_data[0], 32'd0);
         end
      end
      idle();
      #1;
      chk("resweep_done", {31'b0, init_done}, 32'd1);
      chk("x4_zero", rd_data[0], 32'd0);
      chk("x4_zero_nb", rd_data_nb[0], 32'd0);
      chk("x6_not_pend", {31'b0, rd_pending[1]}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
